// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for the shared multiply/divide units: runs the unit enables for a fixed
// cycle count, then pulses the HI/LO writes. Optional div-by-zero trap: MULDIV_DIV0_CHECK_EN.
module muldiv_seq #(
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic div0,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic div0_excp,
  output logic multControl,
  output logic divControl,
  output logic himultControl,
  output logic lomultControl,
  output logic hidivControl,
  output logic lodivControl
);

  localparam logic [5:0] MultLoad = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DivLoad  = 6'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMrun,
    StDrun,
    StMwr,
`ifdef MULDIV_DIV0_CHECK_EN
    StDwr,
    StExcp
`else
    StDwr
`endif
  } state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic excp;
    logic mult;
    logic div;
    logic hm;
    logic lm;
    logic hd;
    logic ld;
  } outs_t;

  state_e     r_state, w_state_next;
  logic [5:0] r_cnt, w_cnt_next;
  outs_t      r_outs, w_outs_next;

  // Outputs are registered from the next-state decode so they line up with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_outs  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_outs  <= w_outs_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (abort) begin
          w_state_next = StIdle;
        end else if (start_mult) begin
          w_state_next = StMrun;
          w_cnt_next   = MultLoad;
        end else if (start_div) begin
`ifdef MULDIV_DIV0_CHECK_EN
          if (div0) begin
            w_state_next = StExcp;
          end else begin
            w_state_next = StDrun;
            w_cnt_next   = DivLoad;
          end
`else
          w_state_next = StDrun;
          w_cnt_next   = DivLoad;
`endif
        end
      end
      StMrun, StDrun: begin
        if (abort) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (r_cnt == 6'd0) begin
          w_state_next = (r_state == StMrun) ? StMwr : StDwr;
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_outs_next      = '0;
    w_outs_next.busy = (w_state_next != StIdle);
    case (w_state_next)
      StMrun: w_outs_next.mult = 1'b1;
      StDrun: w_outs_next.div  = 1'b1;
      StMwr: begin
        w_outs_next.done = 1'b1;
        w_outs_next.hm   = 1'b1;
        w_outs_next.lm   = 1'b1;
      end
      StDwr: begin
        w_outs_next.done = 1'b1;
        w_outs_next.hd   = 1'b1;
        w_outs_next.ld   = 1'b1;
      end
`ifdef MULDIV_DIV0_CHECK_EN
      StExcp: w_outs_next.excp = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy          = r_outs.busy;
  assign done          = r_outs.done;
  assign multControl   = r_outs.mult;
  assign divControl    = r_outs.div;
  assign himultControl = r_outs.hm;
  assign lomultControl = r_outs.lm;
  assign hidivControl  = r_outs.hd;
  assign lodivControl  = r_outs.ld;

`ifdef MULDIV_DIV0_CHECK_EN
  assign div0_excp = r_outs.excp;
`else
  logic w_unused_div0;
  assign w_unused_div0 = div0 ^ r_outs.excp;
  assign div0_excp     = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level elapsed-time model plus directed scenarios
// with hand-computed cycle numbers.
module tb_muldiv_seq;

  localparam int MultCycles = 32;
  localparam int DivCycles  = 32;
`ifdef MULDIV_DIV0_CHECK_EN
  localparam bit Div0Chk = 1'b1;
`else
  localparam bit Div0Chk = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_mult = 1'b0, start_div = 1'b0, div0 = 1'b0, abort = 1'b0;
  logic busy, done, div0_excp, multControl, divControl;
  logic himultControl, lomultControl, hidivControl, lodivControl;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_mult   (start_mult),
    .start_div    (start_div),
    .div0         (div0),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .div0_excp    (div0_excp),
    .multControl  (multControl),
    .divControl   (divControl),
    .himultControl(himultControl),
    .lomultControl(lomultControl),
    .hidivControl (hidivControl),
    .lodivControl (lodivControl)
  );

  always #5 clk = ~clk;

  // Model: which operation is active (0 none, 1 mult, 2 div, 3 excp) and cycles since its start.
  int m_kind = 0;
  int m_el   = 0;

  function automatic int op_len(input int kind);
    if (kind == 3) return 1;
    return ((kind == 1) ? MultCycles : DivCycles) + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_kind <= 0;
      m_el   <= 0;
    end else if (m_kind == 0) begin
      if (!abort && start_mult) begin
        m_kind <= 1;
        m_el   <= 1;
      end else if (!abort && start_div) begin
        m_kind <= (div0 && Div0Chk) ? 3 : 2;
        m_el   <= 1;
      end
    end else if (abort || m_el == op_len(m_kind)) begin
      m_kind <= 0;
      m_el   <= 0;
    end else begin
      m_el <= m_el + 1;
    end
  end

  function automatic logic [8:0] model_outs(input int kind, input int el);
    int  n;
    logic run, wr;
    n   = (kind == 1) ? MultCycles : DivCycles;
    run = (kind == 1 || kind == 2) && el <= n;
    wr  = (kind == 1 || kind == 2) && el == n + 1;
    return {kind != 0, wr, kind == 3, run && kind == 1, run && kind == 2,
            wr && kind == 1, wr && kind == 1, wr && kind == 2, wr && kind == 2};
  endfunction

  int cyc = 0;
  always @(negedge clk) begin
    logic [8:0] act, exp_v;
    cyc++;
    act   = {busy, done, div0_excp, multControl, divControl,
             himultControl, lomultControl, hidivControl, lodivControl};
    exp_v = model_outs(m_kind, m_el);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0d: outputs %b expected %b", cyc, act, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  typedef struct {
    int run_m, run_d, first_run, last_run, done_at, done_n, hl_m, hl_d, excp_at, idle_at;
  } res_t;

  // Start pulse sampled at edge 0; cycle c is observed at the negedge after edge c-1.
  task automatic run_op(input bit sm, input bit sd, input bit d0, input int sec_div,
                        input int abort_at, input int ncyc, output res_t r);
    r = '{default: 0};
    start_mult = sm;
    start_div  = sd;
    div0       = d0;
    @(posedge clk);
    #2;
    start_mult = 1'b0;
    start_div  = 1'b0;
    div0       = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (multControl) r.run_m++;
      if (divControl) r.run_d++;
      if (multControl || divControl) begin
        if (r.first_run == 0) r.first_run = c;
        r.last_run = c;
      end
      if (done) begin
        r.done_at = c;
        r.done_n++;
      end
      if (himultControl || lomultControl) r.hl_m++;
      if (hidivControl || lodivControl) r.hl_d++;
      if (div0_excp) r.excp_at = c;
      if (!busy && r.idle_at == 0) r.idle_at = c;
      start_div = (c == sec_div);
      abort     = (c == abort_at);
    end
    start_div = 1'b0;
    abort     = 1'b0;
  endtask

  res_t r;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_mult", multControl, 0);

    // MULT alone
    run_op(1, 0, 0, 0, 0, 40, r);
    chk("mult_run_cnt", r.run_m, 32);
    chk("mult_first", r.first_run, 1);
    chk("mult_last", r.last_run, 32);
    chk("mult_done_at", r.done_at, 33);
    chk("mult_done_n", r.done_n, 1);
    chk("mult_hilo", r.hl_m, 1);
    chk("mult_idle_at", r.idle_at, 34);

    // DIV with zero divisor
    run_op(0, 1, 1, 0, 0, 40, r);
    if (Div0Chk) begin
      chk("d0_excp_at", r.excp_at, 1);
      chk("d0_run_d", r.run_d, 0);
      chk("d0_hilo", r.hl_d, 0);
      chk("d0_done_n", r.done_n, 0);
      chk("d0_idle_at", r.idle_at, 2);
    end else begin
      chk("d0_excp_at", r.excp_at, 0);
      chk("d0_run_d", r.run_d, 32);
      chk("d0_hilo", r.hl_d, 1);
      chk("d0_done_at", r.done_at, 33);
      chk("d0_idle_at", r.idle_at, 34);
    end

    // Both starts together, then a DIV start in cycle 10
    run_op(1, 1, 0, 10, 0, 40, r);
    chk("both_run_m", r.run_m, 32);
    chk("both_run_d", r.run_d, 0);
    chk("both_hl_d", r.hl_d, 0);
    chk("both_done_at", r.done_at, 33);

    // DIV aborted in cycle 15
    run_op(0, 1, 0, 0, 15, 40, r);
    chk("abort_run_d", r.run_d, 15);
    chk("abort_idle_at", r.idle_at, 16);
    chk("abort_hl_d", r.hl_d, 0);
    chk("abort_done_n", r.done_n, 0);

    // Start in the done cycle is dropped
    run_op(1, 0, 0, 33, 0, 70, r);
    chk("b2b_done_run_d", r.run_d, 0);
    chk("b2b_done_n", r.done_n, 1);

    // Start in the first idle cycle is accepted
    run_op(1, 0, 0, 34, 0, 70, r);
    chk("b2b_idle_run_d", r.run_d, 32);
    chk("b2b_idle_done_n", r.done_n, 2);
    chk("b2b_idle_done_at", r.done_at, 67);
    chk("b2b_idle_hl_d", r.hl_d, 1);

    // Async reset mid-cycle 20 of a MULT
    start_mult = 1'b1;
    @(posedge clk);
    #2;
    start_mult = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mult", multControl, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    run_op(0, 1, 0, 0, 0, 40, r);
    chk("arst_hl_m", r.hl_m, 0);
    chk("post_div_run", r.run_d, 32);
    chk("post_div_done_at", r.done_at, 33);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the shared multiply and divide units in the multicycle CPU datapath. Accepts one-cycle start requests from the main control FSM and drives the unit enables and cycle count. Pulses the HI/LO register write enables at completion and returns a done or divide-by-zero handshake. The main FSM holds its MULT/DIV state while `busy` is high.

## Interface
- `MULT_CYCLES`, 32: cycles the multiplier enable is held (1..63).
- `DIV_CYCLES`, 32: cycles the divider enable is held (1..63).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_mult`  in  1  one-cycle request to start a MULT.
- `start_div`  in  1  one-cycle request to start a DIV.
- `div0`  in  1  divisor-is-zero flag from the divider; sampled in the start cycle.
- `abort`  in  1  synchronous cancel of the current operation.
- `busy`  out  1  high from the cycle after an accepted start until the cycle after the final state.
- `done`  out  1  one-cycle pulse; the operation completed and HI/LO are written.
- `div0_excp`  out  1  one-cycle pulse; divide by zero detected.
- `multControl`  out  1  multiplier run enable.
- `divControl`  out  1  divider run enable.
- `himultControl`, `lomultControl`  out  1 each  HI/LO load from the multiplier.
- `hidivControl`, `lodivControl`  out  1 each  HI/LO load from the divider.

## Operation
- States: IDLE, MRUN, DRUN, MWR, DWR, EXCP. All outputs are registered Moore decodes of the state.
- IDLE:
  - `start_mult` → MRUN and load the counter with `MULT_CYCLES-1`.
  - `start_div` with `div0`=0 → DRUN and load the counter with `DIV_CYCLES-1`.
  - `start_div` with `div0`=1 → EXCP.
- If both starts are asserted together, MULT wins and the DIV request is dropped.
- Start requests are ignored in every state other than IDLE. No queuing.
- MRUN and DRUN:
  - `multControl` (MRUN) or `divControl` (DRUN) is high.
  - The counter decrements every cycle.
  - At counter=0, the next state is MWR or DWR.
- MWR: `himultControl`=`lomultControl`=1 and `done`=1 for one cycle, then IDLE.
- DWR: `hidivControl`=`lodivControl`=1 and `done`=1 for one cycle, then IDLE.
- EXCP: `div0_excp`=1 for one cycle, no HI/LO write, `done`=0, then IDLE.
- `abort` in MRUN, DRUN, MWR, DWR or EXCP → IDLE next cycle. The state being left still drives its outputs in the abort cycle.
- `abort` in IDLE has priority over a start presented in the same cycle; the start is dropped.
- Counter: 6 bits, unsigned. It never wraps, because the transition at 0 is taken before any further decrement.
- `busy` = state != IDLE.
- Reset, asynchronous at any point including mid-run: state → IDLE, counter → 0, every output → 0. No HI/LO write occurs for the interrupted operation.

## Timing
- Start sampled at edge 0.
- MULT:
  - `multControl` high for cycles 1..`MULT_CYCLES`.
  - `done` and HI/LO write in cycle `MULT_CYCLES`+1.
  - IDLE in cycle `MULT_CYCLES`+2.
- DIV: same pattern with `DIV_CYCLES`.
- Div-by-zero: `div0_excp` in cycle 1, IDLE in cycle 2.
- Back-to-back:
  - The next start is accepted in the first IDLE cycle, so minimum spacing between accepted starts is `MULT_CYCLES`+2.
  - A start issued in the same cycle as `done` is ignored.
- Reset values: `busy`=`done`=`div0_excp`=0, all enables 0.

## Configuration
- `MULDIV_DIV0_CHECK_EN` defined:
  - `div0` is sampled at DIV start.
  - A zero divisor produces EXCP and `div0_excp`, with no unit run and no HI/LO write.
- `MULDIV_DIV0_CHECK_EN` undefined:
  - `div0` is ignored and the EXCP state is not built.
  - Every DIV runs DRUN→DWR and writes HI/LO; the zero-divisor result is undefined.
  - `div0_excp` is tied to 0.

## Test plan
- Reset held, then released, with no starts → all outputs 0, `busy`=0 indefinitely.
- `start_mult` pulse at cycle 0 (default parameters):
  - `multControl`=1 for cycles 1–32.
  - `himultControl`=`lomultControl`=`done`=1 in cycle 33 only.
  - `busy` low from cycle 34.
- `start_div` with `div0`=1:
  - Macro defined → `div0_excp`=1 in cycle 1, `divControl` never high, no HI/LO write.
  - Macro undefined → normal 32-cycle DIV, `done` in cycle 33.
- `start_mult` and `start_div` together → MULT sequence only, `divControl` never asserted. A second `start_div` in cycle 10 is ignored.
- `start_div`, then `abort` in cycle 15 → IDLE in cycle 16, `hidivControl`/`lodivControl`/`done` never asserted.
- `start_mult`, then async `reset` asserted mid-cycle 20 → all outputs 0 immediately. After release, a new `start_div` gives `done` 33 cycles after its start.
